// File: rtl/msk_hpc3_rnd_src.sv
// rtl/msk_hpc3_rnd_src.sv - LFSR randomness source feeding an HPC3 masked AND gadget
//
// Purpose:
//   Produces W = d*(d-1) fresh random bits per consumed word from a 64-bit
//   Fibonacci LFSR (x^64+x^63+x^61+x^60+1).  Each advance runs W unrolled
//   LFSR steps, and the feedback bit of step k becomes out_rnd[k].  A seed
//   load is followed by WARMUP free-running advances.  The word produced in
//   the last warm-up cycle is the first word offered to the consumer.
//
// Ports:
//   clk         single clock, rising edge
//   rst         asynchronous active-high reset
//   seed        64-bit seed (0 is replaced by 64'h1)
//   seed_valid  seed offered
//   seed_ready  seed accepted when seed_valid && seed_ready
//   out_rnd     W random bits for the gadget rnd input
//   out_valid   out_rnd holds an unused word
//   out_ready   consumer takes out_rnd this cycle
//   reseed_req  a new seed is required
//
// Optional feature:
//   MSK_RND_SRC_RESEED_LIMIT_EN  when defined, only RESEED_PERIOD handshakes
//                                are allowed per seed, after which the block
//                                returns to IDLE and requests a reseed.
//
// All outputs are registers and depend only on state, so no input reaches
// an output combinationally.

`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

module msk_hpc3_rnd_src #(
   parameter int d             = `DEFAULTSHARES,
   parameter int WARMUP        = 16,
   parameter int RESEED_PERIOD = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [63:0]        seed,
   input  logic               seed_valid,
   output logic               seed_ready,
   output logic [d*(d-1)-1:0] out_rnd,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               reseed_req
);

   localparam int W   = d*(d-1);
   localparam int WCW = $clog2(WARMUP + 1);

   // WARMUP and RESEED_PERIOD must be at least 1; the counters compare
   // against value-1 and a zero setting has no meaningful behaviour.
   if (WARMUP < 1 || RESEED_PERIOD < 1) begin : g_unsupported_params
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WARM = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nx;

   logic [63:0]    s;
   logic [WCW-1:0] warm_cnt;

   logic           seed_acc;
   logic           hs;
   logic           load;
   logic           advance;
   logic           hs_limit;

   logic [63:0]    step_s;
   logic [W-1:0]   step_word;

   assign seed_acc = seed_valid && seed_ready;
   assign hs       = out_valid && out_ready;

   // W unrolled LFSR steps; the feedback of step k is output bit k.
   always_comb begin
      logic fb;
      step_s    = s;
      step_word = '0;
      fb        = 1'b0;
      for (int k = 0; k < W; k++) begin
         fb           = step_s[63] ^ step_s[62] ^ step_s[60] ^ step_s[59];
         step_word[k] = fb;
         step_s       = {step_s[62:0], fb};
      end
   end

`ifdef MSK_RND_SRC_RESEED_LIMIT_EN
   localparam int HCW = $clog2(RESEED_PERIOD + 1);

   logic [HCW-1:0] hs_cnt;

   // Handshake that reaches the budget is the last one this seed may serve.
   assign hs_limit = (hs_cnt == HCW'(RESEED_PERIOD - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hs_cnt <= '0;
      end else if (load) begin
         hs_cnt <= '0;
      end else if (state == RUN && hs) begin
         hs_cnt <= hs_cnt + HCW'(1);
      end
   end
`else
   assign hs_limit = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state and datapath controls
   always_comb begin
      state_nx = state;
      load     = 1'b0;
      advance  = 1'b0;
      case (state)
         IDLE: begin
            if (seed_acc) begin
               load     = 1'b1;
               state_nx = WARM;
            end
         end
         WARM: begin
            advance = 1'b1;
            if (warm_cnt == WCW'(WARMUP - 1)) begin
               state_nx = RUN;
            end
         end
         RUN: begin
            // A seed load wins over a simultaneous handshake; the word on
            // out_rnd that cycle is still treated as consumed.
            if (seed_acc) begin
               load     = 1'b1;
               state_nx = WARM;
            end else if (hs) begin
               advance = 1'b1;
               if (hs_limit) begin
                  state_nx = IDLE;
               end
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s          <= '0;
         warm_cnt   <= '0;
         out_rnd    <= '0;
         out_valid  <= 1'b0;
         seed_ready <= 1'b0;
         reseed_req <= 1'b0;
      end else begin
         seed_ready <= (state_nx != WARM);
         out_valid  <= (state_nx == RUN);
         reseed_req <= (state_nx == IDLE);
         if (load) begin
            s        <= (seed == 64'd0) ? 64'd1 : seed;
            warm_cnt <= '0;
         end else if (advance) begin
            s       <= step_s;
            out_rnd <= step_word;
            if (state == WARM) begin
               warm_cnt <= warm_cnt + WCW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_msk_hpc3_rnd_src.sv
// tb/tb_msk_hpc3_rnd_src.sv - scoreboard bench for msk_hpc3_rnd_src against a bit-sequence model

module tb_msk_hpc3_rnd_src;

   localparam int D      = 2;
   localparam int W      = D*(D-1);
   localparam int WARMUP = 16;
   localparam int PERIOD = 4;
   localparam int NU     = 1024;
   localparam int NW     = 100;

   logic          clk = 1'b0;
   logic          rst;
   logic [63:0]   seed;
   logic          seed_valid;
   logic          seed_ready;
   logic [W-1:0]  out_rnd;
   logic          out_valid;
   logic          out_ready;
   logic          reseed_req;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] seen_q[$];
   logic [W-1:0] stream_a[20];
   bit           u[0:NU-1];

   msk_hpc3_rnd_src #(
      .d             (D),
      .WARMUP        (WARMUP),
      .RESEED_PERIOD (PERIOD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .seed       (seed),
      .seed_valid (seed_valid),
      .seed_ready (seed_ready),
      .out_rnd    (out_rnd),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .reseed_req (reseed_req)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: the LFSR output as a linear recurrence on a bit sequence.
   // u[0..63] are the seed bits from s[63] downward; the feedback of step j
   // is u[j+64] with u[m] = u[m-64]^u[m-63]^u[m-61]^u[m-60].  The first
   // valid word starts at step W*(WARMUP-1).
   task automatic build_model(input logic [63:0] sd);
      logic [63:0]  s0;
      logic [W-1:0] wd;
      s0 = (sd == 64'd0) ? 64'd1 : sd;
      for (int n = 0; n < 64; n++) u[n] = s0[63-n];
      for (int m = 64; m < NU; m++) u[m] = u[m-64] ^ u[m-63] ^ u[m-61] ^ u[m-60];
      exp_q.delete();
      for (int v = 0; v < NW; v++) begin
         for (int k = 0; k < W; k++) wd[k] = u[64 + W*(WARMUP-1) + W*v + k];
         exp_q.push_back(wd);
      end
   endtask

   // Monitor: pops the scoreboard on each handshake and checks hold behaviour.
   initial begin
      bit           p_valid;
      bit           p_ready;
      bit           p_acc;
      logic [W-1:0] p_rnd;
      p_valid = 0;
      p_ready = 0;
      p_acc   = 0;
      p_rnd   = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            p_valid = 0;
         end else begin
            if (p_valid && !p_ready && !p_acc) begin
               check("hold_valid", out_valid, 1);
               check("hold_rnd", out_rnd, p_rnd);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL word_unexpected: got %0h expected no word", out_rnd);
               end else begin
                  check("word", out_rnd, exp_q.pop_front());
               end
               seen_q.push_back(out_rnd);
`ifndef MSK_RND_SRC_RESEED_LIMIT_EN
               check("run_reseed_req", reseed_req, 0);
               check("run_seed_ready", seed_ready, 1);
`endif
            end
            p_valid = out_valid;
            p_ready = out_ready;
            p_acc   = seed_valid && seed_ready;
            p_rnd   = out_rnd;
         end
      end
   end

   // Called 1 time unit after a rising edge; returns at the same phase one
   // edge after out_valid was first seen.  poke offers a rival seed in WARM.
   task automatic load_seed(input logic [63:0] sd, input bit poke);
      int n;
      bit seen;
      check("seed_ready_at_load", seed_ready, 1);
      seed       = sd;
      seed_valid = 1'b1;
      @(posedge clk);
      #1;
      seed_valid = 1'b0;
      build_model(sd);
      seen_q.delete();
      n    = 0;
      seen = 0;
      while (n < 40 && !seen) begin
         @(negedge clk);
         n++;
         if (out_valid) begin
            seen = 1;
         end else begin
            if (n == 2) begin
               check("warm_seed_ready", seed_ready, 0);
               check("warm_reseed_req", reseed_req, 0);
            end
            if (poke && n >= 3 && n <= 5) begin
               check("warm_poke_seed_ready", seed_ready, 0);
               seed       = 64'h0123_4567_89AB_CDEF;
               seed_valid = 1'b1;
            end
            if (poke && n == 6) seed_valid = 1'b0;
         end
      end
      seed_valid = 1'b0;
      check("warmup_latency", n, WARMUP + 1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_words(input int cnt);
      for (int c = 0; c < 200 && seen_q.size() < cnt; c++) begin
         @(posedge clk);
         #1;
      end
      check("word_count_reached", seen_q.size() >= cnt, 1);
   endtask

   task automatic reset_mid_warm();
      out_ready  = 1'b1;
      seed       = 64'h8000_0000_0000_0001;
      seed_valid = 1'b1;
      @(posedge clk);
      #1;
      seed_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_seed_ready", seed_ready, 0);
      check("rst_reseed_req", reseed_req, 0);
      check("rst_out_rnd", out_rnd, 0);
      @(negedge clk);
      rst = 1'b0;
      check("post_rst_seed_ready_low", seed_ready, 0);
      @(posedge clk);
      #1;
      check("post_rst_seed_ready", seed_ready, 1);
      check("post_rst_reseed_req", reseed_req, 1);
      check("post_rst_out_valid", out_valid, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] sd;
      logic [2*20-1:0] pa;
      logic [2*20-1:0] pb;
      logic [W-1:0] hold;
      rst        = 1'b1;
      seed       = '0;
      seed_valid = 1'b0;
      out_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", out_valid, 0);
      check("reset_seed_ready", seed_ready, 0);
      check("reset_reseed_req", reseed_req, 0);
      check("reset_out_rnd", out_rnd, 0);
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("idle_out_valid", out_valid, 0);
      check("idle_seed_ready", seed_ready, 1);
      check("idle_reseed_req", reseed_req, 1);
      check("idle_out_rnd", out_rnd, 0);

`ifndef MSK_RND_SRC_RESEED_LIMIT_EN
      // Seed 1: fourteen zero words, then 2'b10.
      out_ready = 1'b1;
      load_seed(64'd1, 0);
      wait_words(20);
      for (int i = 0; i < 14; i++) check("seed1_zero_word", seen_q[i], 0);
      check("seed1_word15", seen_q[14], 2'b10);
      for (int i = 0; i < 20; i++) stream_a[i] = seen_q[i];

      // Stall: word and valid hold, next handshake continues the stream.
      out_ready = 1'b0;
      @(negedge clk);
      hold = out_rnd;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_valid", out_valid, 1);
         check("stall_rnd", out_rnd, hold);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Seed 0 offered in RUN alongside a handshake, with a rival seed during WARM.
      load_seed(64'd0, 1);
      wait_words(20);
      for (int i = 0; i < 20; i++) begin
         pa[2*i +: 2] = stream_a[i];
         pb[2*i +: 2] = seen_q[i];
      end
      check("seed0_matches_seed1", pb, pa);

      // Random seeds and random consumer back-pressure.
      for (int r = 0; r < 4; r++) begin
         sd = {$urandom, $urandom};
         out_ready = 1'($urandom_range(0, 1));
         load_seed(sd, 0);
         for (int c = 0; c < 60; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
         end
      end
`else
      // Handshake budget: exactly PERIOD words per seed.
      for (int r = 0; r < 2; r++) begin
         sd = {$urandom, $urandom};
         out_ready = 1'b1;
         load_seed(sd, 0);
         for (int c = 0; c < 60; c++) begin
            if (r == 1 && c < 30) out_ready = 1'($urandom_range(0, 1));
            else out_ready = 1'b1;
            @(posedge clk);
            #1;
         end
         check("limit_handshakes", seen_q.size(), PERIOD);
         check("limit_out_valid", out_valid, 0);
         check("limit_reseed_req", reseed_req, 1);
         check("limit_seed_ready", seed_ready, 1);
      end
`endif

      reset_mid_warm();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/msk_hpc3_rnd_src.md
MSK_HPC3_RND_SRC -- requirements
Module: msk_hpc3_rnd_src

Interface
REQ-001 SHALL have parameter d, default `DEFAULTSHARES (2): share count of the consuming HPC3 AND gadget.
REQ-002 SHALL have parameter WARMUP, default 16: cycles the state advances after a seed load before output is valid.
REQ-003 SHALL have parameter RESEED_PERIOD, default 1024: output handshakes allowed per seed (used only under REQ-024).
REQ-004 SHALL define localparam W = d*(d-1): the hpc3rnd width, i.e. two d(d-1)/2 random matrices.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-007 SHALL have port seed, input, 64: PRNG seed value.
REQ-008 SHALL have port seed_valid, input, 1: seed offered.
REQ-009 SHALL have port seed_ready, output, 1: seed accepted when seed_valid and seed_ready are both high.
REQ-010 SHALL have port out_rnd, output, W: fresh randomness for the gadget rnd input.
REQ-011 SHALL have port out_valid, output, 1: out_rnd holds an unused word.
REQ-012 SHALL have port out_ready, input, 1: consumer takes out_rnd this cycle.
REQ-013 SHALL have port reseed_req, output, 1: a new seed is required.

Function
REQ-014 SHALL hold a 64-bit LFSR state s; one step: fb = s[63]^s[62]^s[60]^s[59], s <= {s[62:0], fb} (polynomial x^64+x^63+x^61+x^60+1).
REQ-015 SHALL, per advance cycle, perform W unrolled steps; the fb of step k (k = 0..W-1) is written to out_rnd[k].
REQ-016 SHALL implement FSM IDLE -> WARM -> RUN, entering IDLE on reset.
- IDLE: seed_ready=1, out_valid=0, no advance.
- WARM: seed_ready=0, out_valid=0, advance every cycle for WARMUP cycles, then go to RUN.
- RUN: seed_ready=1, out_valid=1, advance only on an out_valid && out_ready handshake.
REQ-017 SHALL, on seed acceptance in IDLE or RUN, load s = seed (or 64'h1 if seed == 0), clear the warm-up counter, enter WARM next cycle, and perform no advance in the load cycle.
REQ-018 SHALL make the word produced in the final WARM cycle the first valid out_rnd in RUN.
REQ-019 SHALL hold out_rnd and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL give priority to a seed acceptance over a handshake in the same RUN cycle: out_valid drops next cycle, and the word presented in that cycle counts as consumed.
REQ-021 SHALL keep reseed_req=1 in IDLE and 0 in WARM; reseed_req in RUN is defined by Configuration.
REQ-022 SHALL have no combinational path from any input to any output.

Reset
REQ-023 SHALL, while rst=1 and asynchronously: s=0, out_rnd=0, out_valid=0, seed_ready=0, reseed_req=0, all counters=0, state=IDLE; after reset deasserts, seed_ready and reseed_req assert at the first clock edge.

Configuration
REQ-024 SHALL, with MSK_RND_SRC_RESEED_LIMIT_EN defined: count handshakes since the last seed load; after RESEED_PERIOD handshakes, enter IDLE (out_valid=0, reseed_req=1); a new seed clears the count.
REQ-025 SHALL, without MSK_RND_SRC_RESEED_LIMIT_EN: omit the counter, never leave RUN except on reseed, and hold reseed_req=0 in RUN.

Verification
REQ-026 SHALL cover: reset, then 10 idle cycles -> out_valid=0, seed_ready=1, reseed_req=1, out_rnd=0.
REQ-027 SHALL cover: d=2, WARMUP=16, seed=64'h1, out_ready=1 -> out_valid rises 17 cycles after acceptance; the first 14 valid words are 2'b00 and the 15th is 2'b10.
REQ-028 SHALL cover: repeat REQ-027 with seed=0 -> bit-identical word stream.
REQ-029 SHALL cover: in RUN, out_ready=0 for 5 cycles -> out_rnd is unchanged; the first handshake then yields the next word of the REQ-027 stream.
REQ-030 SHALL cover: a seed offered during WARM -> seed_ready=0, not accepted; a seed offered in RUN together with a handshake -> out_valid=0 next cycle, then WARM restarts.
REQ-031 SHALL cover: with MSK_RND_SRC_RESEED_LIMIT_EN and RESEED_PERIOD=4 -> exactly 4 handshakes, then out_valid=0 and reseed_req=1; rst asserted mid-WARM -> all outputs 0 immediately.
